nios_sys_pio_write_initiator: RTL and testbench

NIOS_SYS_PIO_WRITE_INITIATOR -- requirements
Module: nios_sys_pio_write_initiator

---
 rtl/nios_sys_pio_write_initiator_if.sv | 24 ++
 rtl/nios_sys_pio_write_initiator.sv | 159 +++++++++++++++
 tb/tb_nios_sys_pio_write_initiator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/nios_sys_pio_write_initiator_if.sv
// Request handshake and Avalon-MM bus bundle for the PIO write initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface nios_sys_pio_write_initiator_if;
   logic        req_valid;
   logic [3:0]  req_data;
   logic        req_ready;
   logic [1:0]  av_address;
   logic        av_chipselect;
   logic        av_write_n;
   logic        av_read;
   logic [31:0] av_writedata;
   logic [31:0] av_readdata;
   logic        av_waitrequest;

   modport master (
      input  req_valid, req_data, av_readdata, av_waitrequest,
      output req_ready, av_address, av_chipselect, av_write_n, av_read, av_writedata
   );

   modport slave (
      output req_valid, req_data, av_readdata, av_waitrequest,
      input  req_ready, av_address, av_chipselect, av_write_n, av_read, av_writedata
   );
endinterface

// File: rtl/nios_sys_pio_write_initiator.sv
// Writes a 4-bit value to an Avalon-MM PIO data register, optionally reads it back to verify,
// and reports done/error with a bounded tolerance for slave stalls.
module nios_sys_pio_write_initiator #(
   parameter logic [1:0]  PIO_ADDR   = 2'd0,
   parameter bit          READBACK   = 1'b1,
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   nios_sys_pio_write_initiator_if.master        bus,
   output logic                                  done,
   output logic                                  error,
   output logic                                  busy,
   output logic [3:0]                            last_value
);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, FINISH = 2'd3} state_t;

   localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

   state_t      state_r, state_s;
   logic [3:0]  hold_r, hold_s;
   logic [15:0] wait_r, wait_s;
   logic        ready_r, ready_s;
   logic        cs_r, cs_s;
   logic        write_n_r, write_n_s;
   logic        read_r, read_s;
   logic [1:0]  addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic        done_r, done_s;
   logic        error_r, error_s;
   logic        busy_r;
   logic [3:0]  last_r, last_s;

   // Outputs are registered from next-state values so they line up with the state they belong to.
   assign bus.req_ready     = ready_r;
   assign bus.av_chipselect = cs_r;
   assign bus.av_write_n    = write_n_r;
   assign bus.av_read       = read_r;
   assign bus.av_address    = addr_r;
   assign bus.av_writedata  = wdata_r;
   assign done              = done_r;
   assign error             = error_r;
   assign busy              = busy_r;
   assign last_value        = last_r;

   // Next-state and next-output decode for the transaction FSM.
   always_comb begin
      state_s   = state_r;
      hold_s    = hold_r;
      wait_s    = wait_r;
      ready_s   = 1'b0;
      cs_s      = 1'b0;
      write_n_s = 1'b1;
      read_s    = 1'b0;
      addr_s    = addr_r;
      wdata_s   = wdata_r;
      done_s    = 1'b0;
      error_s   = 1'b0;
      last_s    = last_r;
      case (state_r)
         IDLE: begin
            if (ready_r && bus.req_valid) begin
               state_s   = WRITE;
               hold_s    = bus.req_data;
               wait_s    = 16'd0;
               cs_s      = 1'b1;
               write_n_s = 1'b0;
               addr_s    = PIO_ADDR;
               wdata_s   = {28'd0, bus.req_data};
            end else begin
               ready_s = 1'b1;
            end
         end
         WRITE: begin
            if (!bus.av_waitrequest) begin
               if (READBACK) begin
                  state_s = READ;
                  wait_s  = 16'd0;
                  cs_s    = 1'b1;
                  read_s  = 1'b1;
                  addr_s  = PIO_ADDR;
               end else begin
                  state_s = FINISH;
                  done_s  = 1'b1;
                  last_s  = hold_r;
               end
            end else if (wait_r == WAIT_LAST) begin
               state_s = FINISH;
               error_s = 1'b1;
            end else begin
               wait_s    = wait_r + 16'd1;
               cs_s      = 1'b1;
               write_n_s = 1'b0;
            end
         end
         READ: begin
            // Only the low nibble is meaningful; the PIO may return anything above it.
            if (!bus.av_waitrequest) begin
               state_s = FINISH;
               if (bus.av_readdata[3:0] == hold_r) begin
                  done_s = 1'b1;
                  last_s = hold_r;
               end else begin
                  error_s = 1'b1;
               end
            end else if (wait_r == WAIT_LAST) begin
               state_s = FINISH;
               error_s = 1'b1;
            end else begin
               wait_s = wait_r + 16'd1;
               cs_s   = 1'b1;
               read_s = 1'b1;
            end
         end
         FINISH: begin
            state_s = IDLE;
            ready_s = 1'b1;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops every strobe immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         hold_r    <= 4'd0;
         wait_r    <= 16'd0;
         ready_r   <= 1'b0;
         cs_r      <= 1'b0;
         write_n_r <= 1'b1;
         read_r    <= 1'b0;
         addr_r    <= 2'd0;
         wdata_r   <= 32'd0;
         done_r    <= 1'b0;
         error_r   <= 1'b0;
         busy_r    <= 1'b0;
         last_r    <= 4'd0;
      end else begin
         state_r   <= state_s;
         hold_r    <= hold_s;
         wait_r    <= wait_s;
         ready_r   <= ready_s;
         cs_r      <= cs_s;
         write_n_r <= write_n_s;
         read_r    <= read_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
         done_r    <= done_s;
         error_r   <= error_s;
         busy_r    <= (state_s != IDLE);
         last_r    <= last_s;
      end
   end

endmodule

// File: tb/tb_nios_sys_pio_write_initiator.sv
// Randomized scoreboard bench: stimulus pushes expected outcomes, a monitor pops them on done/error.
`timescale 1ns/1ps
module tb_nios_sys_pio_write_initiator;
   localparam logic [1:0] ADDR = 2'd2;
   localparam int         WL   = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       done, error, busy;
   logic [3:0] last_value;

   nios_sys_pio_write_initiator_if bus ();

   nios_sys_pio_write_initiator #(.PIO_ADDR(ADDR), .READBACK(1'b1), .WAIT_LIMIT(WL)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .done(done), .error(error), .busy(busy), .last_value(last_value)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave PIO model: per-transfer stall counts and an optional corrupted read-back.
   int          ws_cfg = 0, rs_cfg = 0, stall_cnt = 0;
   bit          corrupt_cfg = 1'b0;
   logic [27:0] junk_cfg = 28'd0;
   logic [3:0]  pio_reg = 4'd0;

   assign bus.av_waitrequest = bus.av_chipselect && (stall_cnt < (bus.av_read ? rs_cfg : ws_cfg));
   assign bus.av_readdata    = {junk_cfg, corrupt_cfg ? (pio_reg ^ 4'h1) : pio_reg};

   always @(posedge clk) begin
      if (bus.av_chipselect && bus.av_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      if (bus.av_chipselect && !bus.av_write_n && !bus.av_waitrequest) pio_reg <= bus.av_writedata[3:0];
   end

   typedef struct {
      logic [3:0] data;
      bit         ok;
      int         lat;
      int         acc;
      logic [3:0] last;
   } exp_t;
   exp_t       exp_q[$];
   logic [3:0] model_last = 4'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string p);
      chk({p, "_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
      chk({p, "_cs"}, {31'd0, bus.av_chipselect}, 32'd0);
      chk({p, "_write_n"}, {31'd0, bus.av_write_n}, 32'd1);
      chk({p, "_read"}, {31'd0, bus.av_read}, 32'd0);
      chk({p, "_address"}, {30'd0, bus.av_address}, 32'd0);
      chk({p, "_writedata"}, bus.av_writedata, 32'd0);
      chk({p, "_done"}, {31'd0, done}, 32'd0);
      chk({p, "_error"}, {31'd0, error}, 32'd0);
      chk({p, "_busy"}, {31'd0, busy}, 32'd0);
      chk({p, "_last_value"}, {28'd0, last_value}, 32'd0);
   endtask

   // Waits for req_ready, configures the slave for this transaction, predicts its outcome and issues it.
   task automatic issue(input logic [3:0] d, input int ws, input int rs, input bit cor,
                        input logic [27:0] junk, input bit keep, output int acc);
      int   n;
      exp_t e;
      n = 0;
      acc = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         chk("req_ready_timeout", 32'd0, 32'd1);
         return;
      end
      ws_cfg = ws; rs_cfg = rs; corrupt_cfg = cor; junk_cfg = junk;
      bus.req_data = d;
      bus.req_valid = 1'b1;
      acc = cyc;
      e.data = d;
      e.acc  = cyc;
      if (ws >= WL) begin
         e.ok = 1'b0; e.lat = WL + 1;
      end else if (rs >= WL) begin
         e.ok = 1'b0; e.lat = ws + WL + 2;
      end else begin
         e.ok = !cor; e.lat = ws + rs + 3;
      end
      if (e.ok) model_last = d;
      e.last = model_last;
      exp_q.push_back(e);
      @(posedge clk);
      if (!keep) begin
         #1 bus.req_valid = 1'b0;
      end
   endtask

   // Monitor: checks bus strobes against the head transaction and retires it on done/error.
   bit         pend_last = 1'b0;
   logic [3:0] pend_val  = 4'd0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            pend_last = 1'b0;
         end else begin
            if (pend_last) begin
               chk("last_value", {28'd0, last_value}, {28'd0, pend_val});
               chk("ready_after_finish", {31'd0, bus.req_ready}, 32'd1);
               chk("busy_after_finish", {31'd0, busy}, 32'd0);
               pend_last = 1'b0;
            end
            if (bus.av_chipselect && !bus.av_write_n) begin
               chk("wr_address", {30'd0, bus.av_address}, {30'd0, ADDR});
               if (exp_q.size() > 0) chk("wr_data", bus.av_writedata, {28'd0, exp_q[0].data});
               else chk("unexpected_write", 32'd1, 32'd0);
            end
            if (bus.av_chipselect && bus.av_read) begin
               chk("rd_address", {30'd0, bus.av_address}, {30'd0, ADDR});
               chk("rd_write_n", {31'd0, bus.av_write_n}, 32'd1);
            end
            if (done || error) begin
               chk("done_error_exclusive", {31'd0, done & error}, 32'd0);
               chk("finish_strobes", {30'd0, bus.av_chipselect, bus.av_read}, 32'd0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_finish", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done", {31'd0, done}, {31'd0, e.ok});
                  chk("error", {31'd0, error}, {31'd0, !e.ok});
                  chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                  pend_last = 1'b1;
                  pend_val  = e.last;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0, a1, a2, n;
      bus.req_valid = 1'b0;
      bus.req_data  = 4'd0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_first_edge", {31'd0, bus.req_ready}, 32'd1);

      issue(4'hA, 0, 0, 1'b0, 28'd0, 1'b0, a0);
      issue(4'h5, 3, 0, 1'b0, 28'd0, 1'b0, a0);
      issue(4'h5, 0, 0, 1'b0, 28'hFFFFFFF, 1'b0, a0);
      issue(4'h5, 0, 0, 1'b1, 28'hFFFFFFF, 1'b0, a0);
      issue(4'h9, 100, 0, 1'b0, 28'd0, 1'b0, a0);
      issue(4'h6, 0, 100, 1'b0, 28'd0, 1'b0, a0);

      issue(4'h1, 0, 0, 1'b0, 28'd0, 1'b1, a0);
      issue(4'h2, 0, 0, 1'b0, 28'd0, 1'b1, a1);
      issue(4'h3, 0, 0, 1'b0, 28'd0, 1'b0, a2);
      chk("b2b_spacing_12", 32'(a1 - a0), 32'd4);
      chk("b2b_spacing_23", 32'(a2 - a1), 32'd4);

      for (int i = 0; i < 40; i++) begin
         issue(4'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
               ($urandom_range(0, 3) == 0), 28'($urandom), 1'($urandom_range(0, 1)), a0);
      end
      bus.req_valid = 1'b0;

      issue(4'h7, 0, 3, 1'b0, 28'd0, 1'b0, a0);
      n = 0;
      @(negedge clk);
      while (!bus.av_read && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reached_read", {31'd0, bus.av_read}, 32'd1);
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      model_last = 4'd0;
      check_reset_state("midreset");
      repeat (3) @(negedge clk);
      check_reset_state("midreset_hold");
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", {31'd0, bus.req_ready}, 32'd1);
      issue(4'hC, 1, 1, 1'b0, 28'd0, 1'b0, a0);

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
